// File: rtl/byte_bus_target_if.sv
// Byte-serial pin bus between the CPU bus master and the memory-side target.
interface byte_bus_target_if;
    logic       req;
    logic       rd;
    logic       wr;
    logic [7:0] din;
    logic [7:0] dout;
    logic       oe;
    logic       ack;

    modport master (output req, rd, wr, din, input dout, oe, ack);
    modport slave  (input req, rd, wr, din, output dout, oe, ack);
endinterface

// File: rtl/byte_bus_target.sv
// Memory-side target of the byte-serial bus: 3-byte 4-phase transactions into a byte RAM.
// Macro BUS_TARGET_MMIO_EN enables decode of MMIO_ADDR onto the out_port register.
module byte_bus_target #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [15:0] MMIO_ADDR   = 16'hCAFE
) (
    input  logic                    clk,
    input  logic                    rst,
    byte_bus_target_if.slave        bus,
    output logic [7:0]              out_port,
    output logic                    out_strobe,
    output logic                    proto_err
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [1:0]  OP_RD = 2'b10;
    localparam logic [1:0]  OP_WR = 2'b01;

    typedef enum logic [2:0] {IDLE, LO_ACK, HI_WAIT, HI_ACK, DAT_WAIT, DAT_ACK} state_t;

    state_t      state, state_next;
    logic [15:0] addr, addr_next;
    logic [1:0]  op, op_next;
    logic [7:0]  dout_q, dout_next;
    logic        oe_q, oe_next;
    logic        ack_q, ack_next;
    logic [7:0]  port_q, port_next;
    logic        strobe_q, strobe_next;
    logic        err_q, err_next;
    logic        mem_we;
    logic        sreq, srd, swr;
    logic        is_mmio;
    logic [2:0]  sync_q [SYNC_STAGES];
    logic [7:0]  mem [DEPTH];
    logic [ADDR_W-1:0] idx;

    assign idx = addr[ADDR_W-1:0];

`ifdef BUS_TARGET_MMIO_EN
    assign is_mmio = (addr == MMIO_ADDR);
`else
    logic unused_mmio;
    assign is_mmio     = 1'b0;
    assign unused_mmio = ^(addr ^ MMIO_ADDR);
`endif

    // req/rd/wr travel one shared chain so the op flags stay aligned with sreq
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= {bus.req, bus.rd, bus.wr};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign {sreq, srd, swr} = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            addr     <= '0;
            op       <= '0;
            dout_q   <= '0;
            oe_q     <= 1'b0;
            ack_q    <= 1'b0;
            port_q   <= '0;
            strobe_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_next;
            addr     <= addr_next;
            op       <= op_next;
            dout_q   <= dout_next;
            oe_q     <= oe_next;
            ack_q    <= ack_next;
            port_q   <= port_next;
            strobe_q <= strobe_next;
            err_q    <= err_next;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we && !rst) mem[idx] <= bus.din;
    end

    always_comb begin
        state_next  = state;
        addr_next   = addr;
        op_next     = op;
        dout_next   = dout_q;
        port_next   = port_q;
        strobe_next = 1'b0;
        err_next    = err_q;
        mem_we      = 1'b0;

        // an op flag change inside an open transaction aborts it
        if (state != IDLE && {srd, swr} != op) begin
            err_next   = 1'b1;
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (sreq) begin
                        if (srd == swr) begin
                            err_next = 1'b1;
                        end else begin
                            addr_next[7:0] = bus.din;
                            op_next        = {srd, swr};
                            state_next     = LO_ACK;
                        end
                    end
                end
                LO_ACK:  if (!sreq) state_next = HI_WAIT;
                HI_WAIT: begin
                    if (sreq) begin
                        addr_next[15:8] = bus.din;
                        state_next      = HI_ACK;
                    end
                end
                HI_ACK:  if (!sreq) state_next = DAT_WAIT;
                DAT_WAIT: begin
                    if (sreq) begin
                        state_next = DAT_ACK;
                        if (op == OP_WR) begin
                            if (is_mmio) begin
                                port_next   = bus.din;
                                strobe_next = 1'b1;
                            end else begin
                                mem_we = 1'b1;
                            end
                        end else begin
                            dout_next = is_mmio ? port_q : mem[idx];
                        end
                    end
                end
                DAT_ACK: if (!sreq) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end

        ack_next = (state_next == LO_ACK) || (state_next == HI_ACK) || (state_next == DAT_ACK);
        oe_next  = (state_next == DAT_ACK) && (op_next == OP_RD);
    end

    assign bus.dout   = dout_q;
    assign bus.oe     = oe_q;
    assign bus.ack    = ack_q;
    assign out_port   = port_q;
    assign out_strobe = strobe_q;
    assign proto_err  = err_q;
endmodule

// File: tb/tb_byte_bus_target.sv
// Self-checking bench for byte_bus_target: directed table, corner sequences, random vs reference model.
module tb_byte_bus_target;
    localparam int LAT   = 3;
    localparam int BOUND = 20;
`ifdef BUS_TARGET_MMIO_EN
    localparam bit MMIO_ON = 1'b1;
`else
    localparam bit MMIO_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] out_port;
    logic       out_strobe;
    logic       proto_err;
    int         checks = 0;
    int         errors = 0;

    logic [7:0] ref_mem [256];
    logic [7:0] ref_port;

    byte_bus_target_if bus();

    byte_bus_target #(.ADDR_W(8), .SYNC_STAGES(2), .MMIO_ADDR(16'hCAFE)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .out_port(out_port), .out_strobe(out_strobe), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_rd;
        logic [15:0] addr;
        logic [7:0]  data;
        logic [7:0]  exp_dout;
        logic [7:0]  exp_port;
        int          exp_strobes;
    } vec_t;

    vec_t tbl [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic bit is_mmio(input logic [15:0] a);
        return MMIO_ON && (a == 16'hCAFE);
    endfunction

    function automatic logic [7:0] model_read(input logic [15:0] a);
        return is_mmio(a) ? ref_port : ref_mem[a[7:0]];
    endfunction

    task automatic model_write(input logic [15:0] a, input logic [7:0] d);
        if (is_mmio(a)) ref_port = d;
        else            ref_mem[a[7:0]] = d;
    endtask

    task automatic do_reset();
        rst = 1'b1; bus.req = 1'b0; bus.rd = 1'b0; bus.wr = 1'b0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        ref_port = 8'h00;
    endtask

    task automatic raise_wait(input logic [7:0] b, output int strobes);
        int n;
        n = 0; strobes = 0;
        bus.din = b; bus.req = 1'b1;
        while (n < BOUND) begin
            @(negedge clk); n++;
            if (out_strobe) strobes++;
            if (bus.ack) break;
        end
        chk("ack_rise_latency", 32'(n), 32'(LAT));
    endtask

    task automatic fall_wait(input logic exp_oe, output int strobes);
        int n;
        logic oe_err;
        n = 0; strobes = 0; oe_err = 1'b0;
        bus.req = 1'b0;
        while (n < BOUND) begin
            @(negedge clk); n++;
            if (out_strobe) strobes++;
            if (!bus.ack) break;
            if (bus.oe !== exp_oe) oe_err = 1'b1;
        end
        chk("ack_fall_latency", 32'(n), 32'(LAT));
        chk("oe_hold_in_ack", 32'(oe_err), 32'(0));
        chk("oe_after_ack", 32'(bus.oe), 32'(0));
    endtask

    task automatic do_xact(input logic is_rd, input logic [15:0] a, input logic [7:0] d,
                           output logic [7:0] rdata, output int strobes);
        int s;
        strobes = 0;
        bus.rd = is_rd; bus.wr = !is_rd;
        raise_wait(a[7:0], s);  strobes += s;
        chk("oe_addr_lo", 32'(bus.oe), 32'(0));
        fall_wait(1'b0, s);     strobes += s;
        raise_wait(a[15:8], s); strobes += s;
        chk("oe_addr_hi", 32'(bus.oe), 32'(0));
        fall_wait(1'b0, s);     strobes += s;
        raise_wait(d, s);       strobes += s;
        chk("oe_data", 32'(bus.oe), 32'(is_rd));
        rdata = bus.dout;
        fall_wait(is_rd, s);    strobes += s;
    endtask

    // runs one transaction and checks it against the reference model
    task automatic model_xact(input logic is_rd, input logic [15:0] a, input logic [7:0] d);
        logic [7:0] rdata;
        logic [7:0] exp_rd;
        int         st;
        int         exp_st;
        exp_rd = model_read(a);
        exp_st = (!is_rd && is_mmio(a)) ? 1 : 0;
        do_xact(is_rd, a, d, rdata, st);
        if (!is_rd) model_write(a, d);
        if (is_rd) chk($sformatf("model_rd@%04h", a), 32'(rdata), 32'(exp_rd));
        chk("model_strobes", 32'(st), 32'(exp_st));
        chk("model_out_port", 32'(out_port), 32'(ref_port));
    endtask

    initial begin
        logic [7:0] rdata;
        int         st;
        int         acks;

        tbl[0]  = '{1'b0, 16'h0012, 8'h5A, 8'h00, 8'h00, 0};
        tbl[1]  = '{1'b1, 16'h0012, 8'h00, 8'h5A, 8'h00, 0};
        tbl[2]  = '{1'b0, 16'h00FE, 8'h3C, 8'h00, 8'h00, 0};
        tbl[3]  = '{1'b0, 16'hCAFE, 8'h07, 8'h00, MMIO_ON ? 8'h07 : 8'h00, MMIO_ON ? 1 : 0};
        tbl[4]  = '{1'b1, 16'hCAFE, 8'h00, 8'h07, MMIO_ON ? 8'h07 : 8'h00, 0};
        tbl[5]  = '{1'b1, 16'h00FE, 8'h00, MMIO_ON ? 8'h3C : 8'h07, MMIO_ON ? 8'h07 : 8'h00, 0};
        tbl[6]  = '{1'b0, 16'h0100, 8'h11, 8'h00, MMIO_ON ? 8'h07 : 8'h00, 0};
        tbl[7]  = '{1'b1, 16'h0000, 8'h00, 8'h11, MMIO_ON ? 8'h07 : 8'h00, 0};
        tbl[8]  = '{1'b0, 16'h0000, 8'h01, 8'h00, MMIO_ON ? 8'h07 : 8'h00, 0};
        tbl[9]  = '{1'b0, 16'h0001, 8'h01, 8'h00, MMIO_ON ? 8'h07 : 8'h00, 0};
        tbl[10] = '{1'b0, 16'h0002, 8'h02, 8'h00, MMIO_ON ? 8'h07 : 8'h00, 0};
        tbl[11] = '{1'b0, 16'h0003, 8'h00, 8'h00, MMIO_ON ? 8'h07 : 8'h00, 0};
        tbl[12] = '{1'b1, 16'h0000, 8'h00, 8'h01, MMIO_ON ? 8'h07 : 8'h00, 0};
        tbl[13] = '{1'b1, 16'h0001, 8'h00, 8'h01, MMIO_ON ? 8'h07 : 8'h00, 0};
        tbl[14] = '{1'b1, 16'h0002, 8'h00, 8'h02, MMIO_ON ? 8'h07 : 8'h00, 0};
        tbl[15] = '{1'b1, 16'h0003, 8'h00, 8'h00, MMIO_ON ? 8'h07 : 8'h00, 0};
        tbl[16] = '{1'b0, 16'hCAFE, 8'h02, 8'h00, MMIO_ON ? 8'h02 : 8'h00, MMIO_ON ? 1 : 0};
        tbl[17] = '{1'b1, 16'h00FE, 8'h00, MMIO_ON ? 8'h3C : 8'h02, MMIO_ON ? 8'h02 : 8'h00, 0};

        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        ref_port = 8'h00;
        bus.din = 8'h00;
        rst = 1'b1; bus.req = 1'b0; bus.rd = 1'b0; bus.wr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ack", 32'(bus.ack), 32'(0));
        chk("rst_oe", 32'(bus.oe), 32'(0));
        chk("rst_dout", 32'(bus.dout), 32'(0));
        chk("rst_out_port", 32'(out_port), 32'(0));
        chk("rst_out_strobe", 32'(out_strobe), 32'(0));
        chk("rst_proto_err", 32'(proto_err), 32'(0));
        rst = 1'b0;
        @(negedge clk);

        // directed vectors, back to back
        for (int i = 0; i < 18; i++) begin
            do_xact(tbl[i].is_rd, tbl[i].addr, tbl[i].data, rdata, st);
            if (!tbl[i].is_rd) model_write(tbl[i].addr, tbl[i].data);
            if (tbl[i].is_rd) chk($sformatf("tbl%0d_dout", i), 32'(rdata), 32'(tbl[i].exp_dout));
            chk($sformatf("tbl%0d_strobes", i), 32'(st), 32'(tbl[i].exp_strobes));
            chk($sformatf("tbl%0d_out_port", i), 32'(out_port), 32'(tbl[i].exp_port));
        end
        chk("no_err_after_table", 32'(proto_err), 32'(0));

        // rd and wr both set at address-low: error, never acked
        bus.rd = 1'b1; bus.wr = 1'b1; bus.din = 8'h34; bus.req = 1'b1;
        acks = 0;
        repeat (8) begin @(negedge clk); if (bus.ack) acks++; end
        chk("bad_op_no_ack", 32'(acks), 32'(0));
        chk("bad_op_proto_err", 32'(proto_err), 32'(1));
        bus.req = 1'b0; bus.rd = 1'b0; bus.wr = 1'b0;
        repeat (4) @(negedge clk);
        model_xact(1'b0, 16'h0040, 8'h9E);
        model_xact(1'b1, 16'h0040, 8'h00);
        chk("proto_err_sticky", 32'(proto_err), 32'(1));
        do_reset();
        chk("proto_err_cleared", 32'(proto_err), 32'(0));

        // op flag flips between address phases: abort with error
        bus.rd = 1'b0; bus.wr = 1'b1;
        raise_wait(8'h50, st);
        fall_wait(1'b0, st);
        bus.rd = 1'b1; bus.wr = 1'b0;
        repeat (6) @(negedge clk);
        chk("op_change_proto_err", 32'(proto_err), 32'(1));
        chk("op_change_no_ack", 32'(bus.ack), 32'(0));
        bus.rd = 1'b0;
        repeat (3) @(negedge clk);
        do_reset();

        // reset while sitting in the high-address ack
        bus.rd = 1'b0; bus.wr = 1'b1;
        raise_wait(8'h03, st);
        fall_wait(1'b0, st);
        raise_wait(8'h00, st);
        rst = 1'b1; bus.req = 1'b0; bus.wr = 1'b0;
        @(negedge clk);
        chk("midrst_ack", 32'(bus.ack), 32'(0));
        chk("midrst_oe", 32'(bus.oe), 32'(0));
        rst = 1'b0;
        ref_port = 8'h00;
        @(negedge clk);
        do_xact(1'b0, 16'h0003, 8'hA5, rdata, st);
        model_write(16'h0003, 8'hA5);
        do_xact(1'b1, 16'h0003, 8'h00, rdata, st);
        chk("midrst_readback", 32'(rdata), 32'(8'hA5));
        chk("midrst_proto_err", 32'(proto_err), 32'(0));

        // fill RAM so every random read has a defined expectation
        for (int i = 0; i < 256; i++) model_xact(1'b0, 16'(i), 8'($urandom));

        for (int i = 0; i < 150; i++) begin
            logic [15:0] a;
            logic [7:0]  hi;
            case ($urandom_range(0, 3))
                0:       hi = 8'h00;
                1:       hi = 8'hCA;
                default: hi = 8'($urandom);
            endcase
            a = {hi, ($urandom_range(0, 3) == 0) ? 8'hFE : 8'($urandom)};
            model_xact(1'($urandom_range(0, 1)), a, 8'($urandom));
        end
        chk("final_proto_err", 32'(proto_err), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
